pwm_fade_ctrl: RTL

- Sequencer that drives the 4-bit duty input `w` of the PWM LED dimmer.
- Accepts single-beat commands (off, set level, fade to level, breathe) over a valid/ready handshake.
- Steps the duty one LSB per programmable number of PWM frames.
- Duty changes only on PWM frame boundaries, so no glitched partial period reaches the LED.

---
 rtl/pwm_fade_ctrl_pkg.sv | 37 +++
 rtl/pwm_fade_ctrl_if.sv | 15 +
 rtl/pwm_fade_ctrl_frame_div.sv | 36 +++
 rtl/pwm_fade_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared types for the PWM fade sequencer: command codes, FSM states, widths.
package pwm_fade_ctrl_pkg;

    localparam int unsigned DEF_N = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        CMD_OFF     = 2'b00,
        CMD_SET     = 2'b01,
        CMD_FADE    = 2'b10,
        CMD_BREATHE = 2'b11
    } cmd_mode_e;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_FIXED,
        ST_FADE_UP,
        ST_FADE_DN,
        ST_BR_UP,
        ST_BR_HOLD_HI,
        ST_BR_DN,
        ST_BR_HOLD_LO
    } state_e;

    function automatic logic is_busy(input state_e s);
        return !((s == ST_OFF) || (s == ST_FIXED));
    endfunction

    function automatic logic is_fade(input state_e s);
        return (s == ST_FADE_UP) || (s == ST_FADE_DN);
    endfunction

    function automatic logic is_hold(input state_e s);
        return (s == ST_BR_HOLD_HI) || (s == ST_BR_HOLD_LO);
    endfunction

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Single-beat command channel (valid/ready) into the fade sequencer.
interface pwm_fade_ctrl_if #(
    parameter int unsigned N = pwm_fade_ctrl_pkg::DEF_N
) ();
    import pwm_fade_ctrl_pkg::*;

    logic           cmd_valid;
    logic           cmd_ready;
    cmd_mode_e      cmd_mode;
    logic [N-1:0]   cmd_level;

    modport master (output cmd_valid, output cmd_mode, output cmd_level, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_mode, input cmd_level, output cmd_ready);

endinterface

// File: rtl/pwm_fade_ctrl_frame_div.sv
// Frame-tick divider shared by step and hold timing; tc fires on the tick that wraps the count.
module pwm_fade_ctrl_frame_div
    import pwm_fade_ctrl_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tc_c_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_c_o = tick_i && (cnt_q == (period_i - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tc_c_o) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty sequencer for the PWM LED dimmer: off/set/fade/breathe, duty updated only on frame ticks.
module pwm_fade_ctrl
    import pwm_fade_ctrl_pkg::*;
#(
    parameter int unsigned N           = DEF_N,
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            frame_tick_i,
    pwm_fade_ctrl_if.slave  cmd,
    output logic [N-1:0]    duty_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam logic [N-1:0]     DUTY_MAX = {N{1'b1}};
    localparam logic [CNT_W-1:0] STEP_P   = CNT_W'(STEP_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_P   = CNT_W'(HOLD_FRAMES);
    // Zero dwell skips the hold states entirely.
    localparam state_e TOP_NEXT = (HOLD_FRAMES == 0) ? ST_BR_DN : ST_BR_HOLD_HI;
    localparam state_e BOT_NEXT = (HOLD_FRAMES == 0) ? ST_BR_UP : ST_BR_HOLD_LO;

    state_e           state_q, state_d;
    logic [N-1:0]     duty_q, duty_d;
    logic [N-1:0]     tgt_q, tgt_d;
    logic [N-1:0]     plevel_q, plevel_d;
    cmd_mode_e        pmode_q, pmode_d;
    logic             pend_q, pend_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             apply;
    logic             tc;
    logic             div_clear;
    cmd_mode_e        amode;
    logic [N-1:0]     alevel;
    logic [N-1:0]     duty_inc;
    logic [N-1:0]     duty_dec;
    logic [CNT_W-1:0] div_period;

    assign accept     = cmd.cmd_valid && ready_q;
    assign duty_inc   = (duty_q == DUTY_MAX) ? duty_q : duty_q + N'(1);
    assign duty_dec   = (duty_q == '0) ? duty_q : duty_q - N'(1);
    assign div_period = is_hold(state_q) ? HOLD_P : STEP_P;
    assign div_clear  = apply || (state_d != state_q) || !is_busy(state_q);

    pwm_fade_ctrl_frame_div u_frame_div (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .clear_i  (div_clear),
        .tick_i   (frame_tick_i),
        .period_i (div_period),
        .tc_c_o   (tc)
    );

    // Next-state: an applying command overrides any step due on the same tick.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        tgt_d    = tgt_q;
        pend_d   = pend_q;
        pmode_d  = pmode_q;
        plevel_d = plevel_q;
        done_d   = 1'b0;
        apply    = 1'b0;
        amode    = pmode_q;
        alevel   = plevel_q;

        if (accept) begin
            pend_d   = 1'b1;
            pmode_d  = cmd.cmd_mode;
            plevel_d = cmd.cmd_level;
        end

        if (frame_tick_i && (pend_q || accept)) begin
            apply = 1'b1;
            if (!pend_q) begin
                amode  = cmd.cmd_mode;
                alevel = cmd.cmd_level;
            end
        end

        if (apply) begin
            pend_d = 1'b0;
            case (amode)
                CMD_OFF: begin
                    state_d = ST_OFF;
                    duty_d  = '0;
                end
                CMD_SET: begin
                    state_d = ST_FIXED;
                    duty_d  = alevel;
                end
                CMD_FADE: begin
                    tgt_d = alevel;
                    if (alevel > duty_q) begin
                        state_d = ST_FADE_UP;
                    end else if (alevel < duty_q) begin
                        state_d = ST_FADE_DN;
                    end else begin
                        state_d = ST_FIXED;
                        done_d  = 1'b1;
                    end
                end
                CMD_BREATHE: begin
                    tgt_d = alevel;
                    if (alevel == '0) begin
                        state_d = ST_FIXED;
                        duty_d  = '0;
                    end else if (duty_q >= alevel) begin
                        state_d = TOP_NEXT;
                        duty_d  = alevel;
                    end else begin
                        state_d = ST_BR_UP;
                    end
                end
                default: ;
            endcase
        end else if (tc) begin
            case (state_q)
                ST_FADE_UP: begin
                    duty_d = duty_inc;
                    if (duty_inc >= tgt_q) begin
                        state_d = ST_FIXED;
                        done_d  = 1'b1;
                    end
                end
                ST_FADE_DN: begin
                    duty_d = duty_dec;
                    if (duty_dec <= tgt_q) begin
                        state_d = ST_FIXED;
                        done_d  = 1'b1;
                    end
                end
                ST_BR_UP: begin
                    duty_d = duty_inc;
                    if (duty_inc >= tgt_q) begin
                        state_d = TOP_NEXT;
                    end
                end
                ST_BR_HOLD_HI: state_d = ST_BR_DN;
                ST_BR_DN: begin
                    duty_d = duty_dec;
                    if (duty_dec == '0) begin
                        state_d = BOT_NEXT;
                    end
                end
                ST_BR_HOLD_LO: state_d = ST_BR_UP;
                default: ;
            endcase
        end

        ready_d = !pend_d && !is_fade(state_d);
        busy_d  = is_busy(state_d);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_OFF;
            duty_q   <= '0;
            tgt_q    <= '0;
            pend_q   <= 1'b0;
            pmode_q  <= CMD_OFF;
            plevel_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            tgt_q    <= tgt_d;
            pend_q   <= pend_d;
            pmode_q  <= pmode_d;
            plevel_q <= plevel_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign duty_o        = duty_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
